snoop_bus_scheduler: RTL and testbench
======================================

// Module: snoop_bus_scheduler
// PURPOSE
//  Round-robin arbiter and transaction sequencer for the shared snooping bus between processor caches.
//  Picks one requesting cache and drives its start strobe; drives listen to all other caches.
//  Collects snoop hit/writeback responses, then sequences the memory write-back or fill.
//  Sits between the per-processor cache controllers and the main-memory interface.
// PARAMETERS
//  NPROC       4   number of processor caches (2..4)
//  IDX_W       2   processor index width
//  TMO_CYCLES  16  memory-ack timeout in cycles (used only with MEM_TIMEOUT_EN)
// PORTS
//  clock       in   1          clock, rising edge
//  reset       in   1          asynchronous, active-high
//  req         in   NPROC      per-cache bus request, level, held until done
//  req_op      in   NPROC      per-cache op: 0 = read, 1 = write
//  req_block   in   2*NPROC    per-cache block index, packed [2*i+1:2*i]
//  req_tag     in   5*NPROC    per-cache tag, packed [5*i+4:5*i]
//  snoop_hit   in   NPROC      cache i holds the block valid (listeners only)
//  snoop_wb    in   NPROC      cache i holds the block dirty and must write back
//  mem_ack     in   1          memory completed the current rd/wr
//  start       out  NPROC      one-hot; winner performs its CPU action
//  listen      out  NPROC      all non-winners snoop the bus
//  bus_owner   out  IDX_W      index of current winner
//  bus_op      out  1          latched op of winner
//  bus_block   out  2          latched block of winner
//  bus_tag     out  5          latched tag of winner
//  shared      out  1          OR of listener snoop_hit, latched in SNOOP
//  mem_rd      out  1          memory fill request
//  mem_wr      out  1          memory write-back request
//  done        out  NPROC      one-hot, 1-cycle pulse: winner's transaction finished
//  err         out  1          1-cycle pulse with done on timeout abort (0 when macro off)
// BEHAVIOUR
//  Reset: state = IDLE, last_grant = NPROC-1, all outputs 0.
//  FSM: IDLE -> ISSUE -> SNOOP -> {WB | MEM | DONE}; WB -> DONE; MEM -> DONE; DONE -> IDLE.
//  - IDLE: if |req, pick the first requester searching from last_grant+1 with wrap-around.
//    Latch owner, op, block and tag, then go to ISSUE. No request: stay in IDLE.
//  - ISSUE, 1 cycle: start[owner] = 1; listen = ~onehot(owner) & {NPROC{1'b1}}.
//  - SNOOP, 1 cycle: start and listen held. Caches need the second strobe cycle to commit state.
//    Sample snoop_hit and snoop_wb masked to listeners only; the owner's bits are ignored.
//    shared <= |hit_masked.
//    Next state: |wb_masked -> WB; else op == read and !shared -> MEM; else DONE.
//  - WB: start/listen low; mem_wr = 1 until the cycle mem_ack = 1, then DONE.
//    The dirty holder supplies the data to the owner, so no MEM follows.
//  - MEM: mem_rd = 1 until mem_ack, then DONE. Write miss with no sharer also goes to DONE (no MEM).
//  - DONE, 1 cycle: done[owner] = 1; last_grant <= owner; go to IDLE.
//    The owner must drop req on the cycle after done.
//    A req still high in IDLE is treated as a new request, at the lowest round-robin priority.
//  - mem_ack outside WB/MEM is ignored. More than one snoop_wb asserted is legal; a single write-back is performed.
//  - Requests and changes to req_* while busy do not affect the latched transaction.
//  - Reset mid-transaction: immediate abort to IDLE. No done is issued; the pending req re-arbitrates.
//  - Minimum transaction is 4 cycles (IDLE, ISSUE, SNOOP, DONE). Back-to-back grants are at least 4 cycles apart.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a counter runs in WB/MEM.
//    If TMO_CYCLES cycles pass without mem_ack: drop mem_rd/mem_wr, go to DONE, pulse err with done.
//  MEM_TIMEOUT_EN undefined: no counter. WB/MEM wait indefinitely; err is tied to 0.
// TESTING
//  1 reset, req=4'b0000 for 10 cycles -> all outputs 0, state IDLE.
//  2 req=4'b0001, op=read, snoop_hit=0 -> ISSUE start=0001, listen=1110.
//    SNOOP: mem_rd follows; mem_ack 3 cycles later -> done=0001.
//  3 req=4'b1111 held, acking every transaction -> grant order 0,1,2,3,0; done one-hot each time.
//  4 P1 read, snoop_wb=4'b0100 -> mem_wr asserted, mem_rd never asserted.
//    mem_ack -> done=0010, shared=1.
//  5 P2 write, snoop_hit=4'b0100 (owner bit only) -> shared=0.
//    Next state is DONE directly (no mem access), done=0100 at cycle 4.
//  6 reset pulsed during MEM -> mem_rd=0 next edge, no done.
//    MEM_TIMEOUT_EN build: no mem_ack for 16 cycles -> err=1 with done.

Source files
------------

// File: rtl/snoop_bus_scheduler.sv
// Round-robin arbiter and transaction sequencer for a shared snooping cache bus.
// Optional memory-ack timeout is enabled by defining MEM_TIMEOUT_EN.
module snoop_bus_scheduler #(
    parameter int NPROC      = 4,
    parameter int IDX_W      = 2,
    parameter int TMO_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NPROC-1:0]     i_req,
    input  logic [NPROC-1:0]     i_req_op,
    input  logic [2*NPROC-1:0]   i_req_block,
    input  logic [5*NPROC-1:0]   i_req_tag,
    input  logic [NPROC-1:0]     i_snoop_hit,
    input  logic [NPROC-1:0]     i_snoop_wb,
    input  logic                 i_mem_ack,
    output logic [NPROC-1:0]     o_start,
    output logic [NPROC-1:0]     o_listen,
    output logic [IDX_W-1:0]     o_bus_owner,
    output logic                 o_bus_op,
    output logic [1:0]           o_bus_block,
    output logic [4:0]           o_bus_tag,
    output logic                 o_shared,
    output logic                 o_mem_rd,
    output logic                 o_mem_wr,
    output logic [NPROC-1:0]     o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_SNOOP = 3'd2,
        S_WB    = 3'd3,
        S_MEM   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [NPROC-1:0] ONE_HOT0 = {{(NPROC-1){1'b0}}, 1'b1};
    localparam logic [NPROC-1:0] ALL_ONES = {NPROC{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic               w_pick_op;
    logic [1:0]         w_pick_block;
    logic [4:0]         w_pick_tag;
    logic [NPROC-1:0]   w_owner_oh;
    logic [NPROC-1:0]   w_next_oh;
    logic [NPROC-1:0]   w_hit_m;
    logic [NPROC-1:0]   w_wb_m;
    logic               w_strobe_next;
    logic               w_tmo_hit;

    // Round-robin search starting just after the last grant, plus mux of the winner's request fields
    always_comb begin
        w_pick       = r_last;
        w_cand       = r_last;
        w_found      = 1'b0;
        w_pick_op    = 1'b0;
        w_pick_block = 2'b00;
        w_pick_tag   = 5'b00000;
        for (int k = 1; k <= NPROC; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % NPROC);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end else begin
                w_found = w_found;
            end
        end
        for (int p = 0; p < NPROC; p++) begin
            if (w_pick == IDX_W'(p)) begin
                w_pick_op    = i_req_op[p];
                w_pick_block = i_req_block[2*p +: 2];
                w_pick_tag   = i_req_tag[5*p +: 5];
            end else begin
                w_pick_op = w_pick_op;
            end
        end
    end

    assign w_owner_oh = ONE_HOT0 << o_bus_owner;
    assign w_hit_m    = i_snoop_hit & ~w_owner_oh;
    assign w_wb_m     = i_snoop_wb & ~w_owner_oh;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES) + 1;
    logic [TW-1:0] r_tmo;

    assign w_tmo_hit = ((r_state == S_WB) || (r_state == S_MEM)) && !i_mem_ack &&
                       (r_tmo == TW'(TMO_CYCLES - 1));

    // Cycles spent waiting for mem_ack in the current WB/MEM visit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo <= {TW{1'b0}};
        end else if (((r_state == S_WB) || (r_state == S_MEM)) && (w_next == r_state)) begin
            r_tmo <= r_tmo + TW'(1);
        end else begin
            r_tmo <= {TW{1'b0}};
        end
    end
`else
    // Timeout disabled; WB/MEM wait for mem_ack indefinitely.
    assign w_tmo_hit = 1'b0 && (TMO_CYCLES > 0);
`endif

    // Next-state decision
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: w_next = S_SNOOP;
            S_SNOOP: begin
                if (|w_wb_m) begin
                    w_next = S_WB;
                end else if (!o_bus_op && !(|w_hit_m)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_WB, S_MEM: begin
                if (i_mem_ack || w_tmo_hit) begin
                    w_next = S_DONE;
                end else begin
                    w_next = r_state;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // In IDLE the owner register is not loaded yet, so strobes use the fresh pick
    assign w_next_oh     = (r_state == S_IDLE) ? (ONE_HOT0 << w_pick) : w_owner_oh;
    assign w_strobe_next = (w_next == S_ISSUE) || (w_next == S_SNOOP);

    // State, latched transaction and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= IDX_W'(NPROC - 1);
            o_start     <= {NPROC{1'b0}};
            o_listen    <= {NPROC{1'b0}};
            o_bus_owner <= {IDX_W{1'b0}};
            o_bus_op    <= 1'b0;
            o_bus_block <= 2'b00;
            o_bus_tag   <= 5'b00000;
            o_shared    <= 1'b0;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_done      <= {NPROC{1'b0}};
            o_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_found) begin
                o_bus_owner <= w_pick;
                o_bus_op    <= w_pick_op;
                o_bus_block <= w_pick_block;
                o_bus_tag   <= w_pick_tag;
            end
            if (r_state == S_SNOOP) begin
                o_shared <= |w_hit_m;
            end
            if (r_state == S_DONE) begin
                r_last <= o_bus_owner;
            end
            o_start  <= w_strobe_next ? w_next_oh : {NPROC{1'b0}};
            o_listen <= w_strobe_next ? (~w_next_oh & ALL_ONES) : {NPROC{1'b0}};
            o_mem_rd <= (w_next == S_MEM);
            o_mem_wr <= (w_next == S_WB);
            o_done   <= (w_next == S_DONE) ? w_owner_oh : {NPROC{1'b0}};
            o_err    <= (w_next == S_DONE) && w_tmo_hit;
        end
    end

endmodule

// File: tb/tb_snoop_bus_scheduler.sv
// Self-checking bench for snoop_bus_scheduler: vector table with a scoreboard queue,
// plus hand-written round-robin, mid-transaction reset and (MEM_TIMEOUT_EN) timeout sequences.
module tb_snoop_bus_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  i_req = 4'b0000;
    logic [3:0]  i_req_op = 4'b0000;
    logic [7:0]  i_req_block = {2'd0, 2'd1, 2'd2, 2'd3};
    logic [19:0] i_req_tag = {5'd24, 5'd17, 5'd10, 5'd3};
    logic [3:0]  i_snoop_hit = 4'b0000;
    logic [3:0]  i_snoop_wb = 4'b0000;
    logic        i_mem_ack = 1'b0;
    logic [3:0]  o_start, o_listen, o_done;
    logic [1:0]  o_bus_owner, o_bus_block;
    logic        o_bus_op, o_shared, o_mem_rd, o_mem_wr, o_err;
    logic [4:0]  o_bus_tag;

    int n_checks = 0;
    int n_errors = 0;

    snoop_bus_scheduler #(.NPROC(4), .IDX_W(2), .TMO_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_req_op(i_req_op), .i_req_block(i_req_block), .i_req_tag(i_req_tag),
        .i_snoop_hit(i_snoop_hit), .i_snoop_wb(i_snoop_wb), .i_mem_ack(i_mem_ack),
        .o_start(o_start), .o_listen(o_listen), .o_bus_owner(o_bus_owner), .o_bus_op(o_bus_op),
        .o_bus_block(o_bus_block), .o_bus_tag(o_bus_tag), .o_shared(o_shared),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_done(o_done), .o_err(o_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req, op, hit, wb;
        int         ack;
        int         e_own;
        logic [3:0] e_start, e_listen;
        logic       e_op, e_shared, e_rd, e_wr;
        int         e_lat;
    } vec_t;

    typedef struct {
        logic [3:0] st, ls, dn;
        logic [1:0] own, blk;
        logic [4:0] tg;
        logic       op, sh, rd, wr, er;
        int         lat, stc;
    } obs_t;

    vec_t       tbl [8];
    vec_t       sb_q [$];
    logic [3:0] rr_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        i_req     = 4'b0000;
        i_mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Observe one transaction from the cycle after requests are driven until done (bounded)
    task automatic watch(input int ack_delay, output obs_t ob);
        int memc;
        bit fin;
        memc = 0;
        fin  = 1'b0;
        ob   = '{st: 4'b0000, ls: 4'b0000, dn: 4'b0000, own: 2'b00, blk: 2'b00, tg: 5'b00000,
                 op: 1'b0, sh: 1'b0, rd: 1'b0, wr: 1'b0, er: 1'b0, lat: 0, stc: 0};
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clock);
            if (o_start != 4'b0000 && ob.st == 4'b0000) begin
                ob.st  = o_start;
                ob.ls  = o_listen;
                ob.own = o_bus_owner;
                ob.blk = o_bus_block;
                ob.tg  = o_bus_tag;
                ob.op  = o_bus_op;
            end
            if (o_start != 4'b0000) ob.stc++;
            if (o_mem_rd) ob.rd = 1'b1;
            if (o_mem_wr) ob.wr = 1'b1;
            if (o_err) ob.er = 1'b1;
            if (o_mem_rd || o_mem_wr) begin
                memc++;
                i_mem_ack = (memc == ack_delay);
            end else begin
                i_mem_ack = 1'b0;
            end
            if (o_done != 4'b0000) begin
                ob.dn  = o_done;
                ob.sh  = o_shared;
                ob.lat = c;
                fin    = 1'b1;
            end
        end
        i_mem_ack = 1'b0;
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL watch_timeout: got no done expected done within 60 cycles");
        end
    endtask

    initial begin
        obs_t       ob;
        vec_t       ev;
        logic [3:0] eo;
        bit         found, dseen;
        logic [3:0] st;

        // req, op, hit, wb, ack, own, start, listen, op, shared, rd, wr, latency
        tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 3, 0, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 6};
        tbl[1] = '{4'b0010, 4'b0000, 4'b0100, 4'b0100, 2, 1, 4'b0010, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1, 5};
        tbl[2] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 2, 4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        tbl[3] = '{4'b1010, 4'b0000, 4'b0001, 4'b0000, 0, 3, 4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[4] = '{4'b1010, 4'b0000, 4'b0010, 4'b0010, 1, 1, 4'b0010, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        tbl[5] = '{4'b1111, 4'b1111, 4'b0000, 4'b1001, 4, 2, 4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 7};
        tbl[6] = '{4'b1001, 4'b1000, 4'b0001, 4'b0000, 0, 3, 4'b1000, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        tbl[7] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0010, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0, 4};

        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("reset_idle_outputs", 32'({o_start, o_listen, o_bus_owner, o_bus_op, o_bus_block,
                o_bus_tag, o_shared, o_mem_rd, o_mem_wr, o_done, o_err}), 32'd0);
        end

        for (int v = 0; v < 8; v++) begin
            @(negedge clock);
            i_req       = tbl[v].req;
            i_req_op    = tbl[v].op;
            i_snoop_hit = tbl[v].hit;
            i_snoop_wb  = tbl[v].wb;
            sb_q.push_back(tbl[v]);
            watch(tbl[v].ack, ob);
            i_req = 4'b0000;
            ev = sb_q.pop_front();
            chk("vec_start",   32'(ob.st),  32'(ev.e_start));
            chk("vec_listen",  32'(ob.ls),  32'(ev.e_listen));
            chk("vec_owner",   32'(ob.own), 32'(ev.e_own));
            chk("vec_block",   32'(ob.blk), 32'(3 - ev.e_own));
            chk("vec_tag",     32'(ob.tg),  32'(ev.e_own * 7 + 3));
            chk("vec_op",      32'(ob.op),  32'(ev.e_op));
            chk("vec_strobe2", 32'(ob.stc), 32'd2);
            chk("vec_done",    32'(ob.dn),  32'(ev.e_start));
            chk("vec_shared",  32'(ob.sh),  32'(ev.e_shared));
            chk("vec_mem_rd",  32'(ob.rd),  32'(ev.e_rd));
            chk("vec_mem_wr",  32'(ob.wr),  32'(ev.e_wr));
            chk("vec_latency", 32'(ob.lat), 32'(ev.e_lat));
            chk("vec_err",     32'(ob.er),  32'd0);
        end

        // All four request continuously: grants rotate 0,1,2,3,0
        do_reset();
        i_req_op    = 4'b0000;
        i_snoop_hit = 4'b0000;
        i_snoop_wb  = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            i_req = 4'b1111;
            rr_q.push_back(4'b0001 << (k % 4));
            watch(1, ob);
            eo = rr_q.pop_front();
            chk("rr_start", 32'(ob.st), 32'(eo));
            chk("rr_done",  32'(ob.dn), 32'(eo));
        end
        i_req = 4'b0000;

        // Reset while waiting in MEM: abort without done, then the held request re-arbitrates
        do_reset();
        @(negedge clock);
        i_req = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clock);
            if (o_mem_rd) found = 1'b1;
        end
        chk("mid_reach_mem", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1 chk("mid_rd_drop", 32'(o_mem_rd), 32'd0);
        chk("mid_done_low", 32'(o_done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        dseen = 1'b0;
        st    = 4'b0000;
        for (int c = 0; c < 6 && st == 4'b0000; c++) begin
            @(negedge clock);
            if (o_done != 4'b0000) dseen = 1'b1;
            if (o_start != 4'b0000) st = o_start;
        end
        chk("mid_no_done", 32'(dseen), 32'd0);
        chk("mid_regrant", 32'(st), 32'b0001);
        watch(2, ob);
        i_req = 4'b0000;
        chk("mid_done_after", 32'(ob.dn), 32'b0001);

`ifdef MEM_TIMEOUT_EN
        do_reset();
        @(negedge clock);
        i_req = 4'b0001;
        watch(0, ob);
        i_req = 4'b0000;
        chk("tmo_done",    32'(ob.dn),  32'b0001);
        chk("tmo_err",     32'(ob.er),  32'd1);
        chk("tmo_latency", 32'(ob.lat), 32'd19);
        chk("tmo_mem_rd",  32'(ob.rd),  32'd1);
`endif

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
